// File: rtl/noc_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_port_arbiter
//
// Round-robin arbiter for one router output channel. Up to NUM_REQ switch-side
// requesters compete for a single registered output stage. Packets pass
// through unmodified. The fairness pointer (last_grant) makes the scan start
// just after the most recent winner.
//
// Ports:
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous, active-high reset
//   in_valid   in   NUM_REQ        per-requester packet valid
//   in_data    in   NUM_REQ*WIDTH  flattened packets, requester i at [i*WIDTH +: WIDTH]
//   in_ready   out  NUM_REQ        one-hot-or-zero accept (combinational)
//   out_valid  out  1              output register holds a packet
//   out_data   out  WIDTH          registered packet
//   out_src    out  SRC_W          requester index that supplied out_data
//   out_ready  in   1              downstream accept
//
// Optional feature, enabled by defining the macro ARB_STATS_EN:
//   stat_clr   in   1              clear all grant counters
//   stat_cnt   out  NUM_REQ*16     saturating per-requester grant counters,
//                                  requester i at [i*16 +: 16]
// -----------------------------------------------------------------------------
module noc_port_arbiter #(
  parameter int WIDTH   = 39,
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready
`ifdef ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NUM_REQ*16-1:0]    stat_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SRC_W-1:0] out_src_q,   out_src_d;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;

  // Unpacked view of the flattened request data.
  logic [WIDTH-1:0] req_data [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin grant selection
  // Scan last_grant+1, +2, ... modulo NUM_REQ; the first valid requester wins.
  // k runs up to NUM_REQ so the previous winner itself is checked last, which
  // lets a lone requester win every cycle.
  // ---------------------------------------------------------------------------
  logic             grant_found;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Register may take a new packet when empty or being drained this cycle.
  // Nothing is accepted while reset is asserted, so no transfer completes on
  // the reset edge.
  logic can_load;
  logic load_en;

  assign can_load = !out_valid_q || out_ready;
  assign load_en  = can_load && grant_found && !rst;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign in_ready[gi] = load_en && (grant_idx == SRC_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      // Covers the simultaneous drain+load case too: the register is replaced.
      out_valid_d  = 1'b1;
      out_data_d   = req_data[grant_idx];
      out_src_d    = grant_idx;
      last_grant_d = grant_idx;
    end else if (out_valid_q && out_ready) begin
      // Drained with nothing to replace it; data/src keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      // Pointer at the last requester so requester 0 is scanned first.
      last_grant_q <= SRC_W'(NUM_REQ - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  // ---------------------------------------------------------------------------
  // Optional grant statistics
  // ---------------------------------------------------------------------------
`ifdef ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [15:0] stat_cnt_q, stat_cnt_d;

      always_comb begin
        stat_cnt_d = stat_cnt_q;
        if (in_valid[gi] && in_ready[gi] && (stat_cnt_q != 16'hFFFF)) begin
          stat_cnt_d = stat_cnt_q + 16'd1;
        end
      end

      // Clear takes priority over a same-cycle increment.
      always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
          stat_cnt_q <= '0;
        end else begin
          stat_cnt_q <= stat_cnt_d;
        end
      end

      assign stat_cnt[gi*16 +: 16] = stat_cnt_q;
    end
  endgenerate
`endif

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Clocked round-robin arbiter for one router output channel: merges 4 switch-side requesters (local/up/down/left/right switches minus the port's own direction) into one 39-bit packet stream.
- Contains a single output register stage and a fairness pointer; blocks requesters under downstream backpressure.
- Sits between the per-input switches and each router output link, one instance per output direction.

Parameters:
- WIDTH, 39, packet width (type[38:37], x[36:33], y[32:29], payload[28:0]); passed through unmodified.
- NUM_REQ, 4, number of requesters; fixed at 4 in this revision.
- SRC_W, 2, width of source index (clog2 of NUM_REQ).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_REQ  per-requester packet-valid.
- in_data  in  NUM_REQ*WIDTH  flattened packets; requester i at [i*WIDTH +: WIDTH].
- in_ready  out  NUM_REQ  one-hot-or-zero accept, combinational from state and in_valid.
- out_valid  out  1  output register holds a packet.
- out_data  out  WIDTH  registered packet.
- out_src  out  SRC_W  index of requester that supplied out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset: out_valid=0, out_data=0, out_src=0, last_grant=NUM_REQ-1 (so requester 0 wins first), in_ready=0 during reset cycle.
- Transfer on input i = in_valid[i] & in_ready[i]; on output = out_valid & out_ready.
- can_load = !out_valid | out_ready (register empty or draining this cycle).
- Grant: when can_load and any in_valid, g = first i with in_valid[i] scanning last_grant+1, +2, ... modulo NUM_REQ; in_ready[g]=1, all others 0. No request or !can_load -> in_ready=0.
- On input transfer: out_data<=in_data[g], out_src<=g, out_valid<=1, last_grant<=g.
- On output transfer with no input transfer: out_valid<=0; out_data/out_src hold last value.
- Simultaneous output and input transfer: register replaced in same edge; sustained throughput 1 packet/cycle.
- Latency: packet accepted in cycle N is on out_data in cycle N+1.
- Backpressure: out_valid & !out_ready -> out_data/out_src stable, in_ready all 0, last_grant unchanged.
- Upstream rule: in_valid[i] once high stays high with stable data until accepted; arbiter never relies on withdrawal.
- Fairness: any continuously-valid requester is granted within NUM_REQ output transfers.
- Wrap-around: pointer at 3 scans 0,1,2,3.
- Single requester: granted every cycle that can_load holds, regardless of pointer.
- Reset mid-operation: in-flight out_data discarded, out_valid=0 next cycle, pointer reinitialised; no partial transfer completes on the reset edge.
- No packet inspection, modification, duplication or drop.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds ports stat_clr (in, 1) and stat_cnt (out, NUM_REQ*16); per-requester 16-bit grant counters increment on each input transfer, saturate at 16'hFFFF, cleared by rst or stat_clr (clear wins over same-cycle increment).
- Undefined: ports and counters absent; arbitration identical.

Test Plan:
- Reset then in_valid=4'b0001, in_data[0]=39'h1_2200_0E05, out_ready=1 -> in_ready=4'b0001 same cycle; next cycle out_valid=1, out_data=39'h1_2200_0E05, out_src=0.
- in_valid=4'b1111 held, out_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; out_valid continuously 1 after first cycle.
- Output holding packet from src 2, out_ready=0 for 5 cycles with in_valid=4'b1011 -> in_ready=0, out_data/out_src stable; on out_ready=1 next grant is 3, then 0, then 1.
- last_grant=3, only in_valid[3]=1 -> requester 3 granted every cycle (wrap path); then add in_valid[0] -> alternation 0,3,0,3.
- rst asserted one cycle while out_valid=1 and in_valid=4'b0110 -> next cycle out_valid=0, in_ready=0 during reset; after release first grant is requester 1.
- ARB_STATS_EN: 70000 grants to requester 1 -> stat_cnt[31:16]=16'hFFFF; stat_clr coinciding with grant -> 0.
